// File: rtl/muldiv_unit.sv
// Iterative MIPS multiply/divide unit with HI/LO registers.
// Radix-2 shift-add multiply and restoring divide, one bit per cycle.
module muldiv_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             flush,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {IDLE, PREP, RUN, FIX} state_t;

  state_t                 state, state_nxt;
  logic [CW-1:0]          cnt;
  logic                   div_q, sgn_q, neg_q, rneg_q;
  logic [WIDTH-1:0]       a_q, b_q, opa, opb;
  logic [2*WIDTH-1:0]     acc;
  logic signed [WIDTH-1:0] a_s, b_s;
  logic                   a_neg, b_neg;
  logic [WIDTH:0]         mul_sum, div_shift, div_diff;
  logic                   div_ge;
  logic [WIDTH-1:0]       fix_hi, fix_lo;

  function automatic logic [WIDTH-1:0] cond_neg(input logic [WIDTH-1:0] x, input logic n);
    return n ? (~x + WIDTH'(1)) : x;
  endfunction

  function automatic logic [2*WIDTH-1:0] cond_neg2(input logic [2*WIDTH-1:0] x, input logic n);
    return n ? (~x + (2*WIDTH)'(1)) : x;
  endfunction

  assign busy  = (state != IDLE);
  assign a_s   = a_q;
  assign b_s   = b_q;
  assign a_neg = sgn_q && (a_s < 0);
  assign b_neg = sgn_q && (b_s < 0);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (!flush && start && !op[2]) state_nxt = PREP;
      PREP: state_nxt = flush ? IDLE : RUN;
      RUN:  if (flush) state_nxt = IDLE;
            else if (cnt == CW'(WIDTH-1)) state_nxt = FIX;
      FIX:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Multiply step: add multiplicand into the upper half, then shift the whole product right.
  // Divide step: bring the next dividend bit into the partial remainder and trial-subtract.
  always_comb begin
    mul_sum   = {1'b0, acc[2*WIDTH-1:WIDTH]} + (opb[0] ? {1'b0, opa} : '0);
    div_shift = {acc[2*WIDTH-1:WIDTH], opa[WIDTH-1]};
    div_ge    = (div_shift >= {1'b0, opb});
    div_diff  = div_shift - {1'b0, opb};
  end

  // Sign correction; a zero divisor bypasses it and returns the raw dividend.
  always_comb begin
    fix_hi = '0;
    fix_lo = '0;
    if (div_q) begin
      if (b_q == '0) begin
        fix_hi = a_q;
        fix_lo = '1;
      end else begin
        fix_hi = cond_neg(acc[2*WIDTH-1:WIDTH], rneg_q);
        fix_lo = cond_neg(acc[WIDTH-1:0], neg_q);
      end
    end else begin
      {fix_hi, fix_lo} = cond_neg2(acc, neg_q);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      done   <= 1'b0;
      hi     <= '0;
      lo     <= '0;
      cnt    <= '0;
      div_q  <= 1'b0;
      sgn_q  <= 1'b0;
      neg_q  <= 1'b0;
      rneg_q <= 1'b0;
      a_q    <= '0;
      b_q    <= '0;
      opa    <= '0;
      opb    <= '0;
      acc    <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (!flush && start) begin
            if (!op[2]) begin
              a_q   <= a;
              b_q   <= b;
              div_q <= op[1];
              sgn_q <= ~op[0];
            end else if (op[1:0] == 2'b00) begin
              hi <= a;
            end else if (op[1:0] == 2'b01) begin
              lo <= a;
            end
          end
        end
        PREP: begin
          opa    <= cond_neg(a_q, a_neg);
          opb    <= cond_neg(b_q, b_neg);
          neg_q  <= a_neg ^ b_neg;
          rneg_q <= a_neg;
          acc    <= '0;
          cnt    <= '0;
        end
        RUN: begin
          cnt <= cnt + CW'(1);
          if (div_q) begin
            acc <= {(div_ge ? div_diff[WIDTH-1:0] : div_shift[WIDTH-1:0]),
                    acc[WIDTH-2:0], div_ge};
            opa <= opa << 1;
          end else begin
            acc <= {mul_sum, acc[WIDTH-1:1]};
            opb <= opb >> 1;
          end
        end
        FIX: begin
          if (!flush) begin
            hi   <= fix_hi;
            lo   <= fix_lo;
            done <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit: directed cases plus randomized traffic
// compared every cycle against an arithmetic reference model.
module tb_muldiv_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [2:0]  op;
  logic [31:0] a, b;
  logic        flush;
  logic        busy, done;
  logic [31:0] hi, lo;

  int passed = 0;
  int total  = 0;

  muldiv_unit #(.WIDTH(32)) dut (
    .clk(clk), .reset(rst_n), .start(start), .op(op), .a(a), .b(b),
    .flush(flush), .busy(busy), .done(done), .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
  endtask

  // Result of a mult/div as {hi, lo}, straight from the arithmetic definitions.
  function automatic logic [63:0] expect_res(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
    longint p;
    int sx, sy, q, r;
    case (o)
      3'd0: begin
        p = longint'($signed(x)) * longint'($signed(y));
        return 64'(p);
      end
      3'd1: return {32'h0, x} * {32'h0, y};
      3'd2: begin
        if (y == 32'h0) return {x, 32'hFFFFFFFF};
        if (x == 32'h80000000 && y == 32'hFFFFFFFF) return {32'h0, 32'h80000000};
        sx = $signed(x);
        sy = $signed(y);
        q = sx / sy;
        r = sx % sy;
        return {32'(r), 32'(q)};
      end
      3'd3: begin
        if (y == 32'h0) return {x, 32'hFFFFFFFF};
        return {x % y, x / y};
      end
      default: return 64'h0;
    endcase
  endfunction

  // Reference model: remaining cycles until the pending result lands.
  int          remain;
  logic [63:0] pend;
  logic [31:0] m_hi, m_lo;
  logic        m_done;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      remain <= 0;
      pend   <= 64'h0;
      m_hi   <= 32'h0;
      m_lo   <= 32'h0;
      m_done <= 1'b0;
    end else begin
      m_done <= 1'b0;
      if (remain != 0) begin
        if (flush) remain <= 0;
        else begin
          remain <= remain - 1;
          if (remain == 1) begin
            m_hi   <= pend[63:32];
            m_lo   <= pend[31:0];
            m_done <= 1'b1;
          end
        end
      end else if (!flush && start) begin
        if (!op[2]) begin
          pend   <= expect_res(op, a, b);
          remain <= 34;
        end else if (op == 3'd4) m_hi <= a;
        else if (op == 3'd5) m_lo <= a;
      end
    end
  end

  always @(negedge clk) begin
    #1;
    chk("busy", {31'h0, busy}, {31'h0, remain != 0});
    chk("done", {31'h0, done}, {31'h0, m_done});
    chk("hi", hi, m_hi);
    chk("lo", lo, m_lo);
  end

  task automatic issue(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
    start = 1'b1;
    op    = o;
    a     = x;
    b     = y;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done(output int nbusy);
    int n;
    nbusy = 0;
    n = 0;
    while (!done && n < 60) begin
      if (busy) nbusy++;
      @(negedge clk);
      n++;
    end
    chk("done_seen", {31'h0, done}, 32'h1);
  endtask

  int nb;
  logic seen;

  initial begin
    rst_n = 1'b0; start = 1'b0; op = 3'd0; a = 32'h0; b = 32'h0; flush = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_hi", hi, 32'h0);
    chk("rst_lo", lo, 32'h0);
    chk("rst_busy", {31'h0, busy}, 32'h0);
    chk("rst_done", {31'h0, done}, 32'h0);
    rst_n = 1'b1;
    @(negedge clk);

    issue(3'd1, 32'hFFFFFFFF, 32'hFFFFFFFF);
    wait_done(nb);
    chk("multu_hi", hi, 32'hFFFFFFFE);
    chk("multu_lo", lo, 32'h00000001);
    chk("multu_busy_cycles", 32'(nb), 32'd34);
    @(negedge clk);
    chk("done_one_cycle", {31'h0, done}, 32'h0);

    issue(3'd0, 32'hFFFFFFF9, 32'd3);
    wait_done(nb);
    chk("mult_hi", hi, 32'hFFFFFFFF);
    chk("mult_lo", lo, 32'hFFFFFFEB);

    issue(3'd2, 32'hFFFFFFF9, 32'd2);
    wait_done(nb);
    chk("div_hi", hi, 32'hFFFFFFFF);
    chk("div_lo", lo, 32'hFFFFFFFD);

    issue(3'd3, 32'd100, 32'd0);
    wait_done(nb);
    chk("divz_hi", hi, 32'h00000064);
    chk("divz_lo", lo, 32'hFFFFFFFF);

    issue(3'd2, 32'h80000000, 32'hFFFFFFFF);
    wait_done(nb);
    chk("ovf_hi", hi, 32'h0);
    chk("ovf_lo", lo, 32'h80000000);

    start = 1'b1; op = 3'd4; a = 32'h12345678;
    @(negedge clk);
    chk("mthi_hi", hi, 32'h12345678);
    chk("mthi_busy", {31'h0, busy}, 32'h0);
    op = 3'd5; a = 32'h9ABCDEF0;
    @(negedge clk);
    start = 1'b0;
    chk("mtlo_lo", lo, 32'h9ABCDEF0);
    chk("mtlo_hi", hi, 32'h12345678);
    chk("mtlo_done", {31'h0, done}, 32'h0);

    issue(3'd1, 32'd5, 32'd6);
    repeat (9) @(negedge clk);
    issue(3'd3, 32'd9, 32'd3);
    wait_done(nb);
    chk("ignored_hi", hi, 32'h0);
    chk("ignored_lo", lo, 32'd30);
    issue(3'd3, 32'd9, 32'd3);
    wait_done(nb);
    chk("donecyc_hi", hi, 32'h0);
    chk("donecyc_lo", lo, 32'd3);

    start = 1'b1; op = 3'd4; a = 32'hAAAA5555;
    @(negedge clk);
    op = 3'd5; a = 32'h5555AAAA;
    @(negedge clk);
    start = 1'b0;
    issue(3'd3, 32'd1000, 32'd7);
    repeat (14) @(negedge clk);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    chk("flush_busy", {31'h0, busy}, 32'h0);
    seen = 1'b0;
    repeat (40) begin
      @(negedge clk);
      if (done) seen = 1'b1;
    end
    chk("flush_no_done", {31'h0, seen}, 32'h0);
    chk("flush_hi", hi, 32'hAAAA5555);
    chk("flush_lo", lo, 32'h5555AAAA);

    issue(3'd3, 32'd1000, 32'd7);
    repeat (19) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("async_rst_hi", hi, 32'h0);
    chk("async_rst_lo", lo, 32'h0);
    chk("async_rst_busy", {31'h0, busy}, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 4000; i++) begin
      @(negedge clk);
      start = ($urandom_range(3) == 0);
      op    = 3'($urandom_range(7));
      case ($urandom_range(5))
        0: a = 32'h0;
        1: a = 32'h80000000;
        2: a = 32'hFFFFFFFF;
        default: a = $urandom;
      endcase
      case ($urandom_range(6))
        0: b = 32'h0;
        1: b = 32'hFFFFFFFF;
        2: b = 32'(1 + $urandom_range(15));
        default: b = $urandom;
      endcase
      flush = ($urandom_range(59) == 0);
      rst_n = ($urandom_range(1999) != 0);
    end
    @(negedge clk);
    start = 1'b0; flush = 1'b0; rst_n = 1'b1;
    repeat (40) @(negedge clk);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/muldiv_unit.md
Name: muldiv_unit

Overview:
Iterative multi-cycle multiply/divide unit with architectural HI/LO registers for the MIPS pipeline execute stage. Takes operands straight from the register file read ports (via forwarding muxes) and replaces single-cycle combinational multiply/divide. Drives a busy flag so the hazard unit stalls MFHI/MFLO and further mult/div instructions until results are valid.

Parameters:
WIDTH, 32, operand width; HI/LO are WIDTH bits each; iteration count = WIDTH.

Ports:
clk  input  1  clock; all state updates on the rising edge
reset  input  1  asynchronous, active-low reset (reset=0 clears all state immediately)
start  input  1  request a new operation; sampled only in IDLE
op  input  3  000 MULT, 001 MULTU, 010 DIV, 011 DIVU, 100 MTHI, 101 MTLO, others no-op
a  input  WIDTH  rs operand (multiplicand / dividend / MTHI/MTLO source)
b  input  WIDTH  rt operand (multiplier / divisor)
flush  input  1  pipeline flush; aborts an in-flight operation
busy  output  1  high in PREP, RUN, FIX
done  output  1  one-cycle pulse when HI/LO take a mult/div result
hi  output  WIDTH  HI register
lo  output  WIDTH  LO register

Behaviour:
- Reset (reset=0, async): state=IDLE, hi=0, lo=0, busy=0, done=0, counter=0, internal accumulators=0. Takes effect mid-operation too; the result is discarded.
- States: IDLE, PREP, RUN, FIX.
- IDLE:
  - start with op MULT/MULTU/DIV/DIVU -> latch a and b, go to PREP.
  - start with MTHI -> hi<=a at that edge; MTLO -> lo<=a at that edge. Stay in IDLE; busy and done stay 0.
  - Other op codes: no effect.
- PREP (1 cycle):
  - Signed ops: take absolute values of the operands; record the result sign (mult: sign a XOR sign b; quotient: sign a XOR sign b; remainder: sign of a).
  - Unsigned ops: pass operands through unchanged.
  - Clear the 2*WIDTH accumulator; counter=0.
- RUN (exactly WIDTH cycles, counter 0..WIDTH-1):
  - Multiply: radix-2 shift-add, one multiplier bit per cycle, LSB first.
  - Divide: restoring, one quotient bit per cycle, MSB first.
  - Leave RUN at counter==WIDTH-1.
- FIX (1 cycle):
  - Apply sign correction (two's-complement negate where the recorded sign is 1).
  - At the FIX->IDLE edge: hi<=upper half / remainder, lo<=lower half / quotient; done=1 for the following cycle only.
- Latency: start sampled at edge E; hi/lo updated at edge E+WIDTH+2 (34 for WIDTH=32). busy=1 from E through E+WIDTH+2; busy=0 in the done cycle.
- Accepting work:
  - start while busy=1 is ignored (no queuing).
  - start in the done cycle is accepted normally.
- Divide by zero (b==0): lo=all ones, hi=a (raw, before sign handling), for both DIV and DIVU. No exception.
- Signed overflow (DIV, a=most-negative, b=-1): lo=most-negative (0x80000000), hi=0.
- Signed remainder takes the sign of the dividend; quotient truncates toward zero.
- flush=1 in PREP/RUN/FIX: return to IDLE next edge; hi/lo unchanged; no done pulse.
- flush=1 in IDLE: an MTHI/MTLO or start in the same cycle is suppressed. flush has priority over start.
- hi/lo change only via MTHI/MTLO, a FIX completion, or reset.

Test Plan:
- MULTU a=0xFFFFFFFF b=0xFFFFFFFF -> after 34 edges: hi=0xFFFFFFFE, lo=0x00000001, done pulses once, busy high 34 cycles.
- MULT a=-7 (0xFFFFFFF9) b=3 -> hi=0xFFFFFFFF, lo=0xFFFFFFEB. Then DIV a=-7 b=2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF.
- DIVU a=100 b=0 -> lo=0xFFFFFFFF, hi=0x00000064. DIV a=0x80000000 b=0xFFFFFFFF -> lo=0x80000000, hi=0.
- MTHI a=0x12345678 then MTLO a=0x9ABCDEF0 on consecutive cycles -> hi/lo update at each edge, busy=0, done=0.
- MULTU 5*6 started; second start (DIVU 9/3) at cycle 10 -> ignored, final lo=30, hi=0; start in the done cycle -> accepted.
- DIVU 1000/7 with flush at cycle 15 -> IDLE next cycle, hi/lo keep prior values, no done. Repeat with reset=0 at cycle 20 -> hi=lo=0 immediately, busy=0.
